// File: rtl/tc_pkg.sv
// Types and constants shared by the
// tensor-core scratchpad read path.
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } reader_state_t;

  localparam int RD_LATENCY       = 1;
  localparam int STREAM_BUF_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry first-word-fall-through FIFO
// carrying a stream word plus its last flag.
module stream_fifo2 #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wp;
  logic             rp;
  logic [1:0]       cnt;
  logic             wr;
  logic             rd;

  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
  assign rd    = pop & ~empty;
  // a pop frees the slot a same-cycle push lands in
  assign wr    = push & (~full | rd);
  assign dout  = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (rd) rp <= ~rp;
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Turns a (base, len) burst into SRAM reads and a
// valid/ready word stream for the operand path.
module sram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);
  import tc_pkg::*;

  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

  reader_state_t         state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [ADDR_WIDTH:0]   out_left;
  logic                  rd_pending;
  logic                  pend_last;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;
  logic [2:0]            inflight;
  logic [DATA_WIDTH:0]   head;

  assign fifo_count = {fifo_full, ~fifo_empty & ~fifo_full};
  assign pop        = m_valid & m_ready;
  // words buffered plus in flight, after this cycle's pop
  assign inflight   = {1'b0, fifo_count}
                    + {2'b0, rd_pending}
                    - {2'b0, pop};

  assign sram_cs   = (state == ISSUE)
                   && (inflight < 3'(STREAM_BUF_DEPTH));
  assign sram_we   = 1'b0;
  assign sram_addr = rd_addr;

  assign busy    = (state == ISSUE) || (state == DRAIN);
  assign done    = (state == FINISH);
  assign m_valid = ~fifo_empty;
  assign m_data  = head[DATA_WIDTH-1:0];
  assign m_last  = m_valid & head[DATA_WIDTH];

  stream_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (rd_pending),
    .din  ({pend_last, sram_dout}),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      issue_left <= '0;
      out_left   <= '0;
      rd_pending <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      rd_pending <= sram_cs;
      pend_last  <= sram_cs && (issue_left == ONE);
      if (pop) out_left <= out_left - ONE;
      unique case (state)
        IDLE: begin
          if (start) begin
            rd_addr    <= base_addr;
            issue_left <= len;
            out_left   <= len;
            state      <= (len == '0) ? FINISH : ISSUE;
          end
        end
        ISSUE: begin
          if (sram_cs) begin
            rd_addr    <= rd_addr + ADDR_WIDTH'(1);
            issue_left <= issue_left - ONE;
            if (issue_left == ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (out_left == ONE)) state <= FINISH;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
